// File: rtl/cpu_bus_decoder_dma_pkg.sv
// cpu_bus_decoder_dma_pkg: CPU bus region map, OAM DMA constants and states
package cpu_bus_decoder_dma_pkg;
   localparam logic [15:0] RAM_LIMIT = 16'h1FFF;
   localparam logic [15:0] PPU_LIMIT = 16'h3FFF;
   localparam logic [15:0] PRG_BASE = 16'h8000;
   localparam logic [15:0] DMA_REG = 16'h4014;
   localparam logic [2:0] OAMDATA = 3'h4;
   typedef enum logic [2:0] {IDLE, ALIGN, HALT, RD, WR} dma_state_t;
   typedef enum logic [2:0] {R_RAM, R_PPU, R_DMA, R_IO, R_PRG} region_t;
   function automatic region_t decode(input logic [15:0] a);
      return a <= RAM_LIMIT ? R_RAM : a <= PPU_LIMIT ? R_PPU : a == DMA_REG ? R_DMA :
             a < PRG_BASE ? R_IO : R_PRG;
   endfunction
endpackage

// File: rtl/cpu_bus_decoder_dma_oam_dma_engine.sv
// oam_dma_engine: halts the CPU and walks one page as alternating read/OAMDATA-write steps
module oam_dma_engine
   import cpu_bus_decoder_dma_pkg::*;
#(
   parameter int DMA_LEN = 256
) (
   input logic clk,
   input logic rst,
   input logic start,
   input logic parity,
   input logic [7:0] page_in,
   output logic ready,
   output logic dma_rd,
   output logic dma_wr,
   output logic last,
   output logic [15:0] dma_addr
);
   dma_state_t state, state_n;
   logic [7:0] page, idx;
   assign ready = state == IDLE;
   assign dma_rd = state == RD;
   assign dma_wr = state == WR;
   assign last = dma_wr && idx == 8'(DMA_LEN - 1);
   assign dma_addr = {page, idx};
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         page <= '0;
         idx <= '0;
      end else begin
         state <= state_n;
         if (ready && start) begin
            page <= page_in;
            idx <= '0;
         end else if (dma_wr) idx <= last ? 8'd0 : idx + 8'd1;
      end
   end
   always_comb begin
      state_n = state;
      case (state)
         IDLE: if (start) state_n = parity ? ALIGN : HALT;
         ALIGN: state_n = HALT;
         HALT: state_n = RD;
         RD: state_n = WR;
         WR: state_n = last ? IDLE : RD;
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: rtl/cpu_bus_decoder_dma.sv
// cpu_bus_decoder_dma: CPU address decode, work RAM, PPU/PRG forwarding and OAM DMA
module cpu_bus_decoder_dma
   import cpu_bus_decoder_dma_pkg::*;
#(
   parameter int RAM_AW = 11,
   parameter int PRG_AW = 15,
   parameter int DMA_LEN = 256
) (
   input logic clock0,
   input logic reset,
   input logic cpuStrobe,
   input logic [15:0] cpuAddress,
   input logic readNotWrite,
   input logic [7:0] cpuWriteData,
   output logic [7:0] cpuReadData,
   output logic ready,
   output logic [2:0] ppuReg,
   output logic ppuWrite,
   output logic ppuRead,
   output logic [7:0] ppuWriteData,
   input logic [7:0] ppuReadData,
   output logic [PRG_AW-1:0] prgAddress,
   output logic prgRead,
   input logic [7:0] prgReadData
);
   logic [7:0] mem [2**RAM_AW];
   logic [7:0] ram_q, open_bus, cpu_hold, rd_data, hold_d, c_d;
   logic [15:0] hold_a, c_a, acc_a, dma_addr;
   logic hold_rnw, replay, c_rnw, c_go, wr_go, rd_go, rd_cpu, rd_v, start, parity;
   logic dma_rd, dma_wr, dma_rd_g, dma_wr_g, last;
   region_t rgn, src, src_q;
   // a strobe landing on the final DMA write is held and replayed once ready returns
   assign c_a = replay ? hold_a : cpuAddress;
   assign c_rnw = replay ? hold_rnw : readNotWrite;
   assign c_d = replay ? hold_d : cpuWriteData;
   assign c_go = ~reset & (replay | (cpuStrobe & ready));
   assign wr_go = c_go & ~c_rnw;
   assign dma_rd_g = ~reset & dma_rd;
   assign dma_wr_g = ~reset & dma_wr;
   assign acc_a = dma_rd_g ? dma_addr : c_a;
   assign rgn = decode(acc_a);
   assign rd_go = dma_rd_g | (c_go & c_rnw);
   assign src = (dma_rd_g && rgn == R_PPU) ? R_IO : rgn;
   assign start = wr_go && rgn == R_DMA;
   assign ppuWrite = dma_wr_g | (wr_go && rgn == R_PPU);
   assign ppuRead = c_go && c_rnw && rgn == R_PPU;
   assign ppuReg = dma_wr_g ? OAMDATA : (ppuWrite | ppuRead) ? acc_a[2:0] : 3'd0;
   assign ppuWriteData = dma_wr_g ? rd_data : ppuWrite ? c_d : 8'd0;
   assign prgRead = rd_go && rgn == R_PRG;
   assign prgAddress = prgRead ? acc_a[PRG_AW-1:0] : '0;
   assign rd_data = src_q == R_RAM ? ram_q : src_q == R_PPU ? ppuReadData :
                    src_q == R_PRG ? prgReadData : open_bus;
   assign cpuReadData = rd_cpu ? rd_data : cpu_hold;
   always_ff @(posedge clock0) begin
      if (wr_go && rgn == R_RAM) mem[acc_a[RAM_AW-1:0]] <= c_d;
      ram_q <= mem[acc_a[RAM_AW-1:0]];
      if (cpuStrobe) begin
         hold_a <= cpuAddress;
         hold_rnw <= readNotWrite;
         hold_d <= cpuWriteData;
      end
   end
   always_ff @(posedge clock0) begin
      if (reset) begin
         replay <= 1'b0;
         rd_cpu <= 1'b0;
         rd_v <= 1'b0;
         src_q <= R_IO;
         open_bus <= '0;
         cpu_hold <= '0;
         parity <= 1'b0;
      end else begin
         replay <= cpuStrobe & last;
         rd_cpu <= c_go & c_rnw;
         rd_v <= rd_go;
         src_q <= src;
         if (rd_v) open_bus <= rd_data;
         if (rd_cpu) cpu_hold <= rd_data;
         if (cpuStrobe | ~ready) parity <= ~parity;
      end
   end
   oam_dma_engine #(.DMA_LEN(DMA_LEN)) u_dma (
      .clk(clock0),
      .rst(reset),
      .start(start),
      .parity(parity),
      .page_in(c_d),
      .ready(ready),
      .dma_rd(dma_rd),
      .dma_wr(dma_wr),
      .last(last),
      .dma_addr(dma_addr)
   );
endmodule

// File: tb/tb_cpu_bus_decoder_dma.sv
// tb_cpu_bus_decoder_dma: vector table for CPU accesses plus directed OAM DMA sequences
module tb_cpu_bus_decoder_dma;
   typedef struct packed {
      logic [15:0] a;
      logic r;
      logic [7:0] d;
      logic [7:0] e;
   } vec_t;
   logic clk = 0, rst = 1, stb = 0, rnw = 1;
   logic [15:0] addr = 0;
   logic [7:0] wd = 0, rdata, ppu_wd, ppu_rd = 0, prg_rd = 0;
   logic rdy, ppu_w, ppu_r, prg_r;
   logic [2:0] ppu_reg;
   logic [14:0] prg_a;
   int total = 0, bad = 0, low_cnt = 0;
   bit tb_par = 0;
   logic [10:0] wq[$];
   logic s_pw, s_pr, s_prg;
   logic [2:0] s_reg;
   logic [7:0] s_wd, s_rd;
   logic [14:0] s_pa;

   always #5 clk = ~clk;

   cpu_bus_decoder_dma dut (
      .clock0(clk), .reset(rst), .cpuStrobe(stb), .cpuAddress(addr), .readNotWrite(rnw),
      .cpuWriteData(wd), .cpuReadData(rdata), .ready(rdy), .ppuReg(ppu_reg), .ppuWrite(ppu_w),
      .ppuRead(ppu_r), .ppuWriteData(ppu_wd), .ppuReadData(ppu_rd), .prgAddress(prg_a),
      .prgRead(prg_r), .prgReadData(prg_rd)
   );

   function automatic logic [7:0] rom(input logic [14:0] a);
      return a == 15'h7FFC ? 8'h00 : a[7:0] ^ 8'h3C;
   endfunction

   always @(posedge clk) begin
      if (prg_r) prg_rd <= rom(prg_a);
      if (ppu_r) ppu_rd <= {5'b11000, ppu_reg};
   end

   always @(negedge clk) begin
      if (ppu_w) wq.push_back({ppu_reg, ppu_wd});
      if (!rdy) low_cnt++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, want);
      end
   endtask

   task automatic acc(input logic [15:0] a, input logic r, input logic [7:0] d);
      @(posedge clk);
      #2;
      stb = 1; addr = a; rnw = r; wd = d; tb_par ^= 1'b1;
      @(negedge clk);
      s_pw = ppu_w; s_pr = ppu_r; s_prg = prg_r; s_reg = ppu_reg; s_wd = ppu_wd; s_pa = prg_a;
      @(posedge clk);
      #2;
      stb = 0;
      @(negedge clk);
      s_rd = rdata;
   endtask

   task automatic dma_run(input logic [7:0] page, input int mid, input bit rep, input bit from_rom,
                          input string nm);
      int len, bad_el, rep_st;
      bit done;
      logic [7:0] e;
      len = tb_par ? 514 : 513;
      bad_el = 0; rep_st = 0; done = 0;
      wq.delete();
      low_cnt = 0;
      acc(16'h4014, 1'b0, page);
      for (int c = 0; c < 2000 && !done; c++) begin
         @(posedge clk);
         #2;
         stb = 0;
         if (c == mid) begin stb = 1; addr = 16'h4014; rnw = 0; wd = 8'h03; end
         if (rep && rep_st == 1) begin stb = 1; addr = 16'h07FF; rnw = 1; rep_st = 2; end
         else if (rep && rep_st == 0 && wq.size() == 255) rep_st = 1;
         @(negedge clk);
         done = rdy;
      end
      chk({nm, "_done"}, 32'(done), 1);
      chk({nm, "_len"}, low_cnt, len);
      chk({nm, "_cnt"}, wq.size(), 256);
      for (int i = 0; i < wq.size(); i++) begin
         e = from_rom ? rom({page[6:0], 8'(i)}) : 8'(i);
         if (wq[i] !== {3'h4, e}) bad_el++;
      end
      chk({nm, "_data"}, bad_el, 0);
      tb_par ^= len[0];
      if (rep) begin
         @(posedge clk);
         @(negedge clk);
         chk({nm, "_replay"}, rdata, 8'h3C);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t v[15];
      int idle_low;
      v[0] = '{16'h0003, 1'b0, 8'h5A, 8'h00};
      v[1] = '{16'h0803, 1'b1, 8'h00, 8'h5A};
      v[2] = '{16'h1003, 1'b1, 8'h00, 8'h5A};
      v[3] = '{16'h1803, 1'b1, 8'h00, 8'h5A};
      v[4] = '{16'h8010, 1'b1, 8'h00, 8'h2C};
      v[5] = '{16'h4020, 1'b1, 8'h00, 8'h2C};
      v[6] = '{16'h8010, 1'b0, 8'h99, 8'h00};
      v[7] = '{16'h8010, 1'b1, 8'h00, 8'h2C};
      v[8] = '{16'h2002, 1'b1, 8'h00, 8'hC2};
      v[9] = '{16'h200B, 1'b1, 8'h00, 8'hC3};
      v[10] = '{16'h4014, 1'b1, 8'h00, 8'hC3};
      v[11] = '{16'h5000, 1'b0, 8'h11, 8'h00};
      v[12] = '{16'h4000, 1'b1, 8'h00, 8'hC3};
      v[13] = '{16'h07FF, 1'b0, 8'h3C, 8'h00};
      v[14] = '{16'h1FFF, 1'b1, 8'h00, 8'h3C};
      repeat (3) @(posedge clk);
      #2 rst = 0;
      @(negedge clk);
      chk("rst_rdata", rdata, 0);
      chk("rst_ready", rdy, 1);
      chk("rst_ppuw", ppu_w, 0);
      chk("rst_ppur", ppu_r, 0);
      chk("rst_prgr", prg_r, 0);
      chk("rst_prga", prg_a, 0);
      chk("rst_ppureg", ppu_reg, 0);
      chk("rst_ppuwd", ppu_wd, 0);
      for (int i = 0; i < 15; i++) begin
         acc(v[i].a, v[i].r, v[i].d);
         if (v[i].r) chk($sformatf("vec%0d", i), s_rd, v[i].e);
      end
      chk("no_dma_from_io", rdy, 1);
      acc(16'h8010, 1'b1, 8'h00);
      acc(16'h2009, 1'b0, 8'h77);
      chk("ppuw_pulse", s_pw, 1);
      chk("ppuw_reg", s_reg, 3'h1);
      chk("ppuw_data", s_wd, 8'h77);
      acc(16'h4020, 1'b1, 8'h00);
      chk("openbus_not_wdata", s_rd, 8'h2C);
      acc(16'hFFFC, 1'b1, 8'h00);
      chk("prg_read", s_prg, 1);
      chk("prg_addr", s_pa, 15'h7FFC);
      chk("prg_data", s_rd, 8'h00);
      acc(16'h2008, 1'b0, 8'hAB);
      chk("ppu_mirror_reg", s_reg, 3'h0);
      acc(16'h2005, 1'b1, 8'h00);
      chk("ppur_pulse", s_pr, 1);
      chk("ppur_data", s_rd, 8'hC5);
      for (int i = 0; i < 256; i++) acc({8'h02, 8'(i)}, 1'b0, 8'(i));
      if (tb_par) acc(16'h0000, 1'b1, 8'h00);
      dma_run(8'h02, -1, 1'b0, 1'b0, "dma_even");
      if (!tb_par) acc(16'h0000, 1'b1, 8'h00);
      dma_run(8'h02, 50, 1'b0, 1'b0, "dma_odd");
      idle_low = 0;
      repeat (10) begin
         @(negedge clk);
         if (!rdy) idle_low++;
      end
      chk("busy_write_ignored", idle_low, 0);
      acc(16'h0200, 1'b1, 8'h00);
      chk("pre_ff_read", s_rd, 8'h00);
      dma_run(8'hFF, -1, 1'b1, 1'b1, "dma_ff");
      if (tb_par) acc(16'h0200, 1'b1, 8'h00);
      wq.delete();
      acc(16'h4014, 1'b0, 8'h02);
      for (int c = 0; c < 1000 && wq.size() < 100; c++) begin
         @(posedge clk);
         #2;
      end
      chk("rst_mid_reach", wq.size(), 100);
      rst = 1;
      @(posedge clk);
      #2 rst = 0;
      @(negedge clk);
      chk("rst_mid_ready", rdy, 1);
      repeat (20) @(posedge clk);
      #2;
      chk("rst_mid_nowrite", wq.size(), 100);
      tb_par = 0;
      dma_run(8'h02, -1, 1'b0, 1'b0, "dma_after_rst");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
